regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter Addr_width, default 4, address width; depth = 2**Addr_width words.
REQ-002 Parameter data_width, default 8, word width in bits.
REQ-003 Parameter N_RD, default 2, number of asynchronous read ports (range 1..8).
REQ-004 Parameter ZERO_REG, default 0, when 1 location 0 is hardwired to zero.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 we  input  1  write enable.
REQ-008 addr_w  input  Addr_width  write address.
REQ-009 data_w  input  data_width  write data.
REQ-010 clear_req  input  1  request a full-array clear sweep.
REQ-011 addr_r  input  N_RD*Addr_width  read addresses, port i at bits [i*Addr_width +: Addr_width].
REQ-012 data_r  output  N_RD*data_width  read data, port i at bits [i*data_width +: data_width].
REQ-013 busy  output  1  high while a clear sweep is in progress.
REQ-014 wr_drop  output  1  registered one-cycle pulse flagging a write that was ignored.

Function
REQ-015 The block SHALL have two states, IDLE and CLEAR, plus a clear counter clr_cnt of Addr_width bits.
REQ-016 In CLEAR, the block SHALL write zero to mem[clr_cnt] each cycle and increment clr_cnt.
REQ-017 When clr_cnt = depth-1 in CLEAR, the block SHALL transition to IDLE on the next edge; the sweep therefore lasts exactly depth cycles.
REQ-018 In IDLE, clear_req=1 SHALL move the block to CLEAR with clr_cnt=0 on the next edge.
REQ-019 clear_req in CLEAR SHALL be ignored; the sweep neither restarts nor extends.
REQ-020 busy SHALL equal 1 exactly when the state is CLEAR.
REQ-021 In IDLE, we=1 SHALL write data_w to mem[addr_w] on the rising edge.
REQ-022 With ZERO_REG=1, writes to address 0 SHALL be discarded and do not raise wr_drop.
REQ-023 Writes with we=1 while busy=1 SHALL be discarded; wr_drop SHALL be 1 in the following cycle only.
REQ-024 Each read port SHALL be combinational: data_r[i] = mem[addr_r[i]] with no clock latency.
REQ-025 Write-through bypass: in IDLE, if we=1, addr_r[i]=addr_w and the write is not discarded, data_r[i] SHALL equal data_w in the same cycle.
REQ-026 With ZERO_REG=1, any read of address 0 SHALL return 0 regardless of array contents or bypass.
REQ-027 While busy=1, all data_r ports SHALL return 0.
REQ-028 Multiple read ports addressing the same location SHALL all return the same value.

Reset
REQ-029 On a rising edge with rst=1, the block SHALL enter CLEAR with clr_cnt=0, set wr_drop=0, and discard any write.
REQ-030 While rst is held high, the block SHALL remain in CLEAR with clr_cnt=0 and busy=1.
REQ-031 After rst falls, the block SHALL clear locations 0..depth-1 in depth cycles and then enter IDLE.
REQ-032 rst asserted mid-sweep SHALL restart the sweep from clr_cnt=0.
REQ-033 Array contents SHALL be all-zero whenever busy first falls after reset or after a clear_req.

Verification (Addr_width=4, data_width=8, N_RD=2 unless stated)
REQ-034 rst for 1 cycle, then release -> busy=1 for exactly 16 cycles, then 0; every address reads 0x00.
REQ-035 IDLE, write 0xA5 to addr 3, with addr_r0=3 in the same cycle -> data_r0=0xA5 via bypass; next cycle 0xA5 from the array.
REQ-036 clear_req pulse after filling all addresses with 0xFF, then we=1 to addr 5 with 0x11 at sweep cycle 2 -> wr_drop=1 one cycle later; after busy falls, addr 5 reads 0x00.
REQ-037 rst asserted at sweep cycle 9 for one cycle -> busy stays 1, sweep restarts, busy falls 16 cycles after rst release.
REQ-038 ZERO_REG=1: write 0x7E to addr 0, read addr 0 on both ports -> 0x00, wr_drop=0.
REQ-039 N_RD=4: write distinct values to addrs 1,2,3,4, read all four ports concurrently -> each returns its value; all ports set to addr 2 -> all return addr 2 data.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with async reads, write bypass and clear sweep
// A zero sweep runs after reset or clear_req; writes during the sweep are dropped and flagged.
module regfile_mp #(
  parameter int Addr_width = 4,
  parameter int data_width = 8,
  parameter int N_RD       = 2,
  parameter int ZERO_REG   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [Addr_width-1:0]      addr_w,
  input  logic [data_width-1:0]      data_w,
  input  logic                       clear_req,
  input  logic [N_RD*Addr_width-1:0] addr_r,
  output logic [N_RD*data_width-1:0] data_r,
  output logic                       busy,
  output logic                       wr_drop
);

  localparam int Depth = 1 << Addr_width;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [Addr_width-1:0] clr_cnt, clr_cnt_nxt;
  logic [data_width-1:0] mem [Depth];

  logic addr_w_zero;
  logic wr_commit;
  logic wr_ignored;
  logic last_slot;

  // Location 0 swallows writes silently when hardwired, even during a sweep.
  assign addr_w_zero = (ZERO_REG != 0) && (addr_w == '0);
  assign wr_commit   = !rst && (state == IDLE) && we && !addr_w_zero;
  assign wr_ignored  = (state == CLEAR) && we && !addr_w_zero;
  assign last_slot   = (clr_cnt == Addr_width'(Depth - 1));
  assign busy        = (state == CLEAR);

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    unique case (state)
      IDLE: begin
        if (clear_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + Addr_width'(1);
        if (last_slot) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      wr_drop <= wr_ignored;
    end
  end

  // The array itself is never reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (wr_commit) begin
        mem[addr_w] <= data_w;
      end
    end
  end

  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    logic [Addr_width-1:0] rd_addr;
    logic [data_width-1:0] rd_data;

    assign rd_addr = addr_r[i*Addr_width +: Addr_width];

    always_comb begin
      rd_data = mem[rd_addr];
      if (busy || ((ZERO_REG != 0) && (rd_addr == '0))) begin
        rd_data = '0;
      end else if (wr_commit && (rd_addr == addr_w)) begin
        rd_data = data_w;
      end
    end

    assign data_r[i*data_width +: data_width] = rd_data;
  end

endmodule
